// File: rtl/ibexc_sleep_ctrl_pkg.sv
// Shared types for the sleep/clock-enable controller.
// The sleep_state_e encoding is reused by assertions and the bench.
package ibexc_sleep_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        DRAIN = 3'd1,
        HOLD  = 3'd2,
        SLEEP = 3'd3,
        WAKE  = 3'd4
    } sleep_state_e;

    localparam logic [31:0] SleepCntMax = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == SleepCntMax) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ibexc_outstanding_cnt.sv
// Saturating outstanding-transaction counter with a sticky over/underflow flag.
// Reusable for any request/response bus that needs drain tracking.
module ibexc_outstanding_cnt #(
    parameter int OutstW = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [OutstW-1:0] count_o,
    output logic              zero_o,
    output logic              error_o
);

    localparam logic [OutstW-1:0] CntMax = '1;

    logic [OutstW-1:0] r_count;
    logic              r_error;

    // Simultaneous inc and dec cancel; the out-of-range side holds and flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_error <= 1'b0;
        end else if (inc_i && !dec_i) begin
            if (r_count == CntMax) begin
                r_error <= 1'b1;
            end else begin
                r_count <= r_count + OutstW'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (r_count == '0) begin
                r_error <= 1'b1;
            end else begin
                r_count <= r_count - OutstW'(1);
            end
        end
    end

    assign count_o = r_count;
    assign zero_o  = (r_count == '0);
    assign error_o = r_error;

endmodule

// File: rtl/ibexc_sleep_ctrl.sv
// Multi-source wake / clock-enable controller for the core clock gate.
// Optional SLEEP-cycle counter (sleep_cnt_o) is built when IBEXC_SLEEP_CNT_EN is defined.
module ibexc_sleep_ctrl
    import ibexc_sleep_ctrl_pkg::*;
#(
    parameter int NumWake    = 4,
    parameter int HystCycles = 8,
    parameter int OutstW     = 2,
    parameter int SrcW       = (NumWake > 1) ? $clog2(NumWake) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               core_busy_i,
    input  logic               test_en_i,
    input  logic [NumWake-1:0] wake_i,
    input  logic [NumWake-1:0] wake_en_i,
    input  logic [NumWake-1:0] wake_edge_i,
    input  logic               bus_req_i,
    input  logic               bus_gnt_i,
    input  logic               bus_rvalid_i,
    output logic               clk_en_o,
    output logic               core_sleep_o,
    output logic [NumWake-1:0] wake_pending_o,
    output logic [SrcW-1:0]    wake_src_o,
    output logic               proto_err_o,
    output sleep_state_e       dbg_state_o,
    output logic [OutstW-1:0]  dbg_outst_o
`ifdef IBEXC_SLEEP_CNT_EN
    ,
    output logic [31:0]        sleep_cnt_o
`endif
);

    localparam int HystW = (HystCycles > 1) ? $clog2(HystCycles) : 1;
    localparam logic [HystW-1:0] HystLoad = (HystCycles > 0) ? HystW'(HystCycles - 1) : '0;

    sleep_state_e      r_state;
    logic [HystW-1:0]  r_hyst;
    logic              r_sleep;
    logic [SrcW-1:0]   r_src;
    logic [NumWake-1:0] r_wake_q;
    logic [NumWake-1:0] r_pending;

    logic [NumWake-1:0] w_rise;
    logic [NumWake-1:0] w_wake_act;
    logic               w_any_wake;
    logic [SrcW-1:0]    w_src;
    logic               w_outst_zero;
    logic               w_outst_err;
    logic [OutstW-1:0]  w_outst;
    logic               w_drained;
    logic               w_wake_or_busy;

    ibexc_outstanding_cnt #(
        .OutstW (OutstW)
    ) u_outst (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (bus_req_i & bus_gnt_i),
        .dec_i   (bus_rvalid_i),
        .count_o (w_outst),
        .zero_o  (w_outst_zero),
        .error_o (w_outst_err)
    );

    // Edge-mode wakes are latched so a short pulse survives until WAKE.
    assign w_rise         = wake_i & ~r_wake_q;
    assign w_wake_act     = (wake_i & wake_en_i & ~wake_edge_i) | (r_pending & wake_en_i);
    assign w_any_wake     = |w_wake_act;
    assign w_drained      = w_outst_zero & ~bus_req_i;
    assign w_wake_or_busy = core_busy_i | w_any_wake;

    always_comb begin
        w_src = '0;
        for (int i = NumWake - 1; i >= 0; i--) begin
            if (w_wake_act[i]) begin
                w_src = SrcW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wake_q  <= '0;
            r_pending <= '0;
        end else begin
            r_wake_q  <= wake_i;
            r_pending <= ((r_state == WAKE) ? '0 : r_pending) | (w_rise & wake_edge_i);
        end
    end

    // r_sleep mirrors (r_state == SLEEP) so the gate enable comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_hyst  <= '0;
            r_sleep <= 1'b0;
            r_src   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (!w_wake_or_busy) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_wake_or_busy) begin
                        r_state <= RUN;
                    end else if (w_drained) begin
                        if (HystCycles == 0) begin
                            r_state <= SLEEP;
                            r_sleep <= 1'b1;
                        end else begin
                            r_state <= HOLD;
                            r_hyst  <= HystLoad;
                        end
                    end
                end
                HOLD: begin
                    if (w_wake_or_busy) begin
                        r_state <= RUN;
                    end else if (bus_req_i) begin
                        r_state <= DRAIN;
                    end else if (r_hyst == '0) begin
                        r_state <= SLEEP;
                        r_sleep <= 1'b1;
                    end else begin
                        r_hyst <= r_hyst - HystW'(1);
                    end
                end
                SLEEP: begin
                    if (w_any_wake) begin
                        r_state <= WAKE;
                        r_sleep <= 1'b0;
                        r_src   <= w_src;
                    end
                end
                WAKE: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                    r_sleep <= 1'b0;
                end
            endcase
        end
    end

`ifdef IBEXC_SLEEP_CNT_EN
    logic [31:0] r_sleep_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sleep_cnt <= '0;
        end else if (r_state == SLEEP) begin
            r_sleep_cnt <= sat_inc32(r_sleep_cnt);
        end
    end

    assign sleep_cnt_o = r_sleep_cnt;
`endif

    assign clk_en_o       = ~r_sleep | test_en_i;
    assign core_sleep_o   = r_sleep;
    assign wake_pending_o = r_pending;
    assign wake_src_o     = r_src;
    assign proto_err_o    = w_outst_err;
    assign dbg_state_o    = r_state;
    assign dbg_outst_o    = w_outst;

endmodule

// File: tb/tb_ibexc_sleep_ctrl.sv
// Self-checking bench for ibexc_sleep_ctrl (default parameters).
// Valid/ready note: a bus accept is bus_req_i & bus_gnt_i in one cycle; bus_rvalid_i retires one.
module tb_ibexc_sleep_ctrl;
    import ibexc_sleep_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       core_busy = 1'b0;
    logic       test_en = 1'b0;
    logic [3:0] wake = '0;
    logic [3:0] wake_en = '0;
    logic [3:0] wake_edge = 4'b0100;
    logic       bus_req = 1'b0;
    logic       bus_gnt = 1'b0;
    logic       bus_rvalid = 1'b0;

    logic         clk_en;
    logic         core_sleep;
    logic [3:0]   wake_pending;
    logic [1:0]   wake_src;
    logic         proto_err;
    sleep_state_e dbg_state;
    logic [1:0]   dbg_outst;
`ifdef IBEXC_SLEEP_CNT_EN
    logic [31:0]  sleep_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [13:0] exp_q[$];
    string       name_q[$];

    ibexc_sleep_ctrl #(
        .NumWake    (4),
        .HystCycles (8),
        .OutstW     (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .core_busy_i    (core_busy),
        .test_en_i      (test_en),
        .wake_i         (wake),
        .wake_en_i      (wake_en),
        .wake_edge_i    (wake_edge),
        .bus_req_i      (bus_req),
        .bus_gnt_i      (bus_gnt),
        .bus_rvalid_i   (bus_rvalid),
        .clk_en_o       (clk_en),
        .core_sleep_o   (core_sleep),
        .wake_pending_o (wake_pending),
        .wake_src_o     (wake_src),
        .proto_err_o    (proto_err),
        .dbg_state_o    (dbg_state),
        .dbg_outst_o    (dbg_outst)
`ifdef IBEXC_SLEEP_CNT_EN
        ,
        .sleep_cnt_o    (sleep_cnt)
`endif
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // {state, clk_en, core_sleep, pending, src, proto_err, outst}
    function automatic logic [13:0] ex(input logic [2:0] s, input logic ce, input logic sl,
                                       input logic [3:0] p, input logic [1:0] src,
                                       input logic err, input logic [1:0] o);
        return {s, ce, sl, p, src, err, o};
    endfunction

    task automatic drive(input logic busy, input logic te, input logic req, input logic gnt,
                         input logic rv, input logic [3:0] w, input logic [3:0] en);
        core_busy  = busy;
        test_en    = te;
        bus_req    = req;
        bus_gnt    = gnt;
        bus_rvalid = rv;
        wake       = w;
        wake_en    = en;
    endtask

    // Scoreboard: push expectation, advance one edge, pop and compare #1 after it.
    task automatic tick_check(input string nm, input logic [13:0] e);
        logic [13:0] act;
        logic [13:0] want;
        string       n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        act  = {dbg_state, clk_en, core_sleep, wake_pending, wake_src, proto_err, dbg_outst};
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got st=%0d ce=%b sl=%b pend=%b src=%0d err=%b out=%0d want st=%0d ce=%b sl=%b pend=%b src=%0d err=%b out=%0d",
                     n, act[13:11], act[10], act[9], act[8:5], act[4:3], act[2], act[1:0],
                     want[13:11], want[10], want[9], want[8:5], want[4:3], want[2], want[1:0]);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    typedef struct {
        logic       busy;
        logic       te;
        logic       req;
        logic       gnt;
        logic       rv;
        logic [3:0] w;
        logic [3:0] en;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int n_extra;

        // Applied starting in SLEEP; each row is the state after its edge.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, ex(SLEEP, 1, 1, 4'b0, 2'd0, 0, 2'd0)};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, ex(SLEEP, 0, 1, 4'b0, 2'd0, 0, 2'd0)};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, ex(SLEEP, 0, 1, 4'b0, 2'd0, 0, 2'd0)};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010, ex(WAKE,  1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, ex(RUN,   1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, ex(DRAIN, 1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, ex(RUN,   1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, ex(DRAIN, 1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, ex(DRAIN, 1, 0, 4'b0, 2'd1, 0, 2'd1)};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, ex(DRAIN, 1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, ex(HOLD,  1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, ex(DRAIN, 1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, ex(HOLD,  1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, ex(RUN,   1, 0, 4'b0, 2'd1, 0, 2'd0)};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, ex(DRAIN, 1, 0, 4'b0, 2'd1, 0, 2'd0)};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick_check("reset", ex(RUN, 1, 0, 4'b0, 2'd0, 0, 2'd0));
`ifdef IBEXC_SLEEP_CNT_EN
        check32("reset_sleep_cnt", sleep_cnt, 32'd0);
`endif

        // Idle from reset release: DRAIN, 8x HOLD, SLEEP on the 10th edge
        rst = 1'b0;
        tick_check("rel_drain", ex(DRAIN, 1, 0, 4'b0, 2'd0, 0, 2'd0));
        for (int k = 2; k <= 9; k++) begin
            tick_check($sformatf("rel_hold%0d", k), ex(HOLD, 1, 0, 4'b0, 2'd0, 0, 2'd0));
        end
        tick_check("rel_sleep", ex(SLEEP, 0, 1, 4'b0, 2'd0, 0, 2'd0));

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].busy, vecs[i].te, vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].w, vecs[i].en);
            tick_check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Drain tracking: three accepts, then three responses, then hysteresis
        drive(0, 0, 1, 1, 0, 4'b0000, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            tick_check($sformatf("acc%0d", k), ex(DRAIN, 1, 0, 4'b0, 2'd1, 0, 2'(k)));
        end
        drive(0, 0, 0, 0, 1, 4'b0000, 4'b0000);
        for (int k = 2; k >= 0; k--) begin
            tick_check($sformatf("rsp_out%0d", k), ex(DRAIN, 1, 0, 4'b0, 2'd1, 0, 2'(k)));
        end
        drive(0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            tick_check($sformatf("drain_hold%0d", k), ex(HOLD, 1, 0, 4'b0, 2'd1, 0, 2'd0));
        end
        tick_check("drain_sleep", ex(SLEEP, 0, 1, 4'b0, 2'd1, 0, 2'd0));

        // Edge-mode pulse on source 2 while sleeping
        drive(0, 0, 0, 0, 0, 4'b0100, 4'b0100);
        tick_check("pulse_latch", ex(SLEEP, 0, 1, 4'b0100, 2'd1, 0, 2'd0));
        drive(0, 0, 0, 0, 0, 4'b0000, 4'b0100);
        tick_check("pulse_wake", ex(WAKE, 1, 0, 4'b0100, 2'd2, 0, 2'd0));
        tick_check("pulse_run", ex(RUN, 1, 0, 4'b0000, 2'd2, 0, 2'd0));

        // Reset mid-HOLD
        tick_check("pre_rst_drain", ex(DRAIN, 1, 0, 4'b0, 2'd2, 0, 2'd0));
        tick_check("pre_rst_hold", ex(HOLD, 1, 0, 4'b0, 2'd2, 0, 2'd0));
        rst = 1'b1;
        tick_check("rst_hold", ex(RUN, 1, 0, 4'b0, 2'd0, 0, 2'd0));
`ifdef IBEXC_SLEEP_CNT_EN
        check32("rst_hold_sleep_cnt", sleep_cnt, 32'd0);
`endif

        // Back to SLEEP, random dwell, then reset mid-SLEEP
        rst = 1'b0;
        tick_check("re_drain", ex(DRAIN, 1, 0, 4'b0, 2'd0, 0, 2'd0));
        for (int k = 2; k <= 9; k++) begin
            tick_check($sformatf("re_hold%0d", k), ex(HOLD, 1, 0, 4'b0, 2'd0, 0, 2'd0));
        end
        tick_check("re_sleep", ex(SLEEP, 0, 1, 4'b0, 2'd0, 0, 2'd0));
        n_extra = $urandom_range(1, 4);
        for (int k = 0; k < n_extra; k++) begin
            tick_check($sformatf("dwell%0d", k), ex(SLEEP, 0, 1, 4'b0, 2'd0, 0, 2'd0));
        end
`ifdef IBEXC_SLEEP_CNT_EN
        check32("sleep_cnt_dwell", sleep_cnt, 32'(n_extra));
`endif
        rst = 1'b1;
        tick_check("rst_sleep", ex(RUN, 1, 0, 4'b0, 2'd0, 0, 2'd0));
`ifdef IBEXC_SLEEP_CNT_EN
        check32("rst_sleep_cnt", sleep_cnt, 32'd0);
`endif

        // Protocol errors: overflow at 3, then simultaneous accept+response, then underflow
        rst = 1'b0;
        drive(1, 0, 1, 1, 0, 4'b0000, 4'b0000);
        tick_check("ovf1", ex(RUN, 1, 0, 4'b0, 2'd0, 0, 2'd1));
        tick_check("ovf2", ex(RUN, 1, 0, 4'b0, 2'd0, 0, 2'd2));
        tick_check("ovf3", ex(RUN, 1, 0, 4'b0, 2'd0, 0, 2'd3));
        tick_check("ovf4", ex(RUN, 1, 0, 4'b0, 2'd0, 1, 2'd3));
        rst = 1'b1;
        tick_check("err_clear", ex(RUN, 1, 0, 4'b0, 2'd0, 0, 2'd0));
        rst = 1'b0;
        drive(1, 0, 1, 1, 1, 4'b0000, 4'b0000);
        tick_check("both_hold", ex(RUN, 1, 0, 4'b0, 2'd0, 0, 2'd0));
        drive(1, 0, 0, 0, 1, 4'b0000, 4'b0000);
        tick_check("udf", ex(RUN, 1, 0, 4'b0, 2'd0, 1, 2'd0));

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
